// File: rtl/fht_pkg.sv
// Shared constants, state encoding and width helpers for the FHT stage sequencer.
package fht_pkg;

    localparam int FHT_N_LOG2 = 10;
    localparam int FHT_RD_LAT = 1;
    localparam int FHT_WR_LAT = FHT_RD_LAT + 2;
    localparam int FHT_ADDR_W = FHT_N_LOG2;
    localparam int FHT_TW_W   = FHT_N_LOG2 - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } fht_state_t;

    // Width of the stage counter, which counts 0..n_log2-1.
    function automatic int stage_w(input int n_log2);
        return (n_log2 > 1) ? $clog2(n_log2) : 1;
    endfunction

endpackage

// File: rtl/fht_addr_gen.sv
// Combinational map from (stage, butterfly index) to read, twiddle and write addresses.
module fht_addr_gen
    import fht_pkg::*;
#(
    parameter int N_LOG2 = FHT_N_LOG2,
    localparam int S_W   = stage_w(N_LOG2)
) (
    input  logic [S_W-1:0]    s,
    input  logic [N_LOG2-2:0] b,
    output logic [N_LOG2-1:0] a0,
    output logic [N_LOG2-1:0] a1,
    output logic [N_LOG2-1:0] a2,
    output logic [N_LOG2-2:0] tw
);

    logic [N_LOG2-1:0] h;
    logic [N_LOG2-1:0] mask;
    logic [N_LOG2-1:0] bx;
    logic [N_LOG2-1:0] j;
    logic [N_LOG2-1:0] base;
    logic [S_W-1:0]    tw_sh;

    always_comb begin
        h     = N_LOG2'(1) << s;
        mask  = h - N_LOG2'(1);
        bx    = {1'b0, b};
        j     = bx & mask;
        // Group index shifted back up by s+1 is just the upper bits of b moved left once.
        base  = (bx & ~mask) << 1;
        a0    = base + j;
        a1    = base + h + j;
        a2    = base + h + ((h - j) & mask);
        tw_sh = S_W'(N_LOG2 - 1) - s;
        tw    = (N_LOG2 - 1)'(j << tw_sh);
    end

endmodule

// File: rtl/fht_ctrl.sv
// FHT stage sequencer: issues one butterfly per cycle, ping-pongs RAM banks per stage.
// Optional issue freeze via iPAUSE when FHT_CTRL_PAUSE_EN is defined.
//
// state | meaning
// IDLE  | waiting for iSTART
// RUN   | issuing butterflies b = 0..N/2-1 of stage s
// FLUSH | WR_LAT idle cycles so the stage's last writes land before the next read
// DONE  | one-cycle completion pulse, then back to IDLE
module fht_ctrl
    import fht_pkg::*;
#(
    parameter int N_LOG2 = FHT_N_LOG2,
    parameter int RD_LAT = FHT_RD_LAT
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic              iSTART,
`ifdef FHT_CTRL_PAUSE_EN
    input  logic              iPAUSE,
`endif
    output logic              oBUSY,
    output logic              oDONE,
    output logic              oRD_BANK,
    output logic [N_LOG2-1:0] oRD_ADDR0,
    output logic [N_LOG2-1:0] oRD_ADDR1,
    output logic [N_LOG2-1:0] oRD_ADDR2,
    output logic              oRD_EN,
    output logic [N_LOG2-2:0] oTW_ADDR,
    output logic              oWR_BANK,
    output logic [N_LOG2-1:0] oWR_ADDR0,
    output logic [N_LOG2-1:0] oWR_ADDR1,
    output logic              oWR_EN,
    output logic              oRES_BANK
);

    localparam int WR_LAT = RD_LAT + 2;
    localparam int S_W    = stage_w(N_LOG2);
    localparam int B_W    = N_LOG2 - 1;
    localparam int C_W    = $clog2(WR_LAT + 1);

    localparam logic [B_W-1:0] B_LAST  = '1;
    localparam logic [S_W-1:0] S_LAST  = S_W'(N_LOG2 - 1);
    localparam logic [C_W-1:0] FL_LAST = C_W'(WR_LAT - 1);

    fht_state_t        st;
    logic [S_W-1:0]    s;
    logic [B_W-1:0]    b;
    logic [C_W-1:0]    fl_cnt;
    logic              pause;
    logic              issue;
    logic [N_LOG2-1:0] a0, a1, a2;
    logic [N_LOG2-2:0] tw;
    logic [N_LOG2-1:0] rd_addr0_q;
    logic [WR_LAT-1:0] wl_v;
    logic [N_LOG2-1:0] wl_y0 [WR_LAT];
    logic [N_LOG2-1:0] wl_y1 [WR_LAT];

`ifdef FHT_CTRL_PAUSE_EN
    assign pause = iPAUSE;
`else
    assign pause = 1'b0;
`endif

    assign issue = (st == ST_RUN) && !pause;

    fht_addr_gen #(.N_LOG2(N_LOG2)) u_addr_gen (
        .s  (s),
        .b  (b),
        .a0 (a0),
        .a1 (a1),
        .a2 (a2),
        .tw (tw)
    );

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            st     <= ST_IDLE;
            s      <= '0;
            b      <= '0;
            fl_cnt <= '0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (iSTART) begin
                        st <= ST_RUN;
                        s  <= '0;
                        b  <= '0;
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        b <= b + B_W'(1);
                        if (b == B_LAST) begin
                            st     <= ST_FLUSH;
                            fl_cnt <= FL_LAST;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (fl_cnt == '0) begin
                        if (s == S_LAST) begin
                            st <= ST_DONE;
                        end else begin
                            s  <= s + S_W'(1);
                            st <= ST_RUN;
                        end
                    end else begin
                        fl_cnt <= fl_cnt - C_W'(1);
                    end
                end
                ST_DONE:  st <= ST_IDLE;
                default:  st <= ST_IDLE;
            endcase
        end
    end

    // X0 trails X1/X2 by a cycle; the write line keeps shifting even while issue is frozen.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            rd_addr0_q <= '0;
            wl_v       <= '0;
            for (int i = 0; i < WR_LAT; i++) begin
                wl_y0[i] <= '0;
                wl_y1[i] <= '0;
            end
        end else begin
            rd_addr0_q <= issue ? a0 : '0;
            wl_v[0]    <= issue;
            wl_y0[0]   <= issue ? a0 : '0;
            wl_y1[0]   <= issue ? a1 : '0;
            for (int i = 1; i < WR_LAT; i++) begin
                wl_v[i]  <= wl_v[i-1];
                wl_y0[i] <= wl_y0[i-1];
                wl_y1[i] <= wl_y1[i-1];
            end
        end
    end

    assign oBUSY     = (st == ST_RUN) || (st == ST_FLUSH);
    assign oDONE     = (st == ST_DONE);
    assign oRD_BANK  = oBUSY & s[0];
    assign oWR_BANK  = oBUSY & ~s[0];
    assign oRD_EN    = issue;
    assign oRD_ADDR1 = issue ? a1 : '0;
    assign oRD_ADDR2 = issue ? a2 : '0;
    assign oTW_ADDR  = issue ? tw : '0;
    assign oRD_ADDR0 = rd_addr0_q;
    assign oWR_EN    = wl_v[WR_LAT-1];
    assign oWR_ADDR0 = wl_y0[WR_LAT-1];
    assign oWR_ADDR1 = wl_y1[WR_LAT-1];
    assign oRES_BANK = 1'(N_LOG2 % 2);

endmodule
